lutram_burst_responder: RTL and testbench
=========================================

Name: lutram_burst_responder

Overview:
- Bus-side responder that serves single and burst word read/write transactions from a cache-style requester.
- Translates them into per-cycle accesses on a dual-port distributed RAM's port 1 (address, enable, byte strobe, write data, read data).
- Sits between a cache/uncached bus master and an on-chip scratchpad or tag/data array.
- One beat per cycle once a transaction is active.

Parameters:
- ADDR_WIDTH, 6, word-address width of the RAM.
- DATA_WIDTH, 64, bits per word/beat.
- BYTE_WIDTH, 8, bits per strobe lane. DATA_WIDTH must be a multiple of it.
- LEN_WIDTH, 4, width of beat-count field. Maximum burst is 2**LEN_WIDTH beats.
- READ_LATENCY, 0, RAM read latency. Only 0 or 1 is legal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  transaction request, held high until the cycle after the last beat
- req_is_write  in  1  1 = write, 0 = read. Stable while req_valid.
- req_addr  in  ADDR_WIDTH  start word address. Stable while req_valid.
- req_len  in  LEN_WIDTH  beats minus 1. Stable while req_valid.
- req_wrap  in  1  1 = WRAP burst, 0 = INCR. Stable while req_valid.
- req_strobe  in  DATA_WIDTH/BYTE_WIDTH  byte enables of current write beat
- req_data  in  DATA_WIDTH  current write beat data
- resp_ready  out  1  current beat accepted (write) or valid (read)
- resp_last  out  1  qualifies the final beat
- resp_data  out  DATA_WIDTH  read beat data
- ram_en  out  1  port-1 write enable
- ram_addr  out  ADDR_WIDTH  port-1 address
- ram_strobe  out  DATA_WIDTH/BYTE_WIDTH  port-1 byte write strobe
- ram_wdata  out  DATA_WIDTH  port-1 write data
- ram_rdata  in  DATA_WIDTH  port-1 read data

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state IDLE; all outputs 0. While reset is high, ram_en=0 and resp_ready=0 regardless of state.
- States:
  - IDLE: on req_valid, latch addr, len, is_write and wrap; beat counter=0; cur_addr=req_addr. Go to PREFETCH if the request is a read and READ_LATENCY=1, else go to ACTIVE.
  - PREFETCH: ram_addr=cur_addr; advance the issue address; go to ACTIVE.
  - ACTIVE: resp_ready=1 every cycle.
    - Write beat: ram_en=1, ram_addr=cur_addr, ram_strobe=req_strobe, ram_wdata=req_data.
    - Read beat: resp_data=ram_rdata. With latency 0, ram_addr=cur_addr. With latency 1, ram_addr is the next issue address.
    - resp_last=1 when counter==len. Counter increments each beat.
    - After the last beat, go to DONE.
  - DONE: one cycle, all outputs 0, req_valid ignored, then go to IDLE. The requester must drop req_valid the cycle after resp_last.
- Timing:
  - Latency 0: first resp_ready two cycles after req_valid rises.
  - Latency 1 reads: first resp_ready three cycles after req_valid rises.
  - Throughput is 1 beat/cycle in all cases.
- Address update:
  - INCR: +1 modulo 2**ADDR_WIDTH.
  - WRAP: only when len+1 is a power of two ≥2. Low log2(len+1) bits increment modulo len+1; upper bits are fixed. WRAP with any other len behaves as INCR.
- Strobe: write beats with strobe=0 still consume a beat and assert resp_ready. Read beats never assert ram_en.
- Data outputs: ram_wdata and ram_strobe are 0 outside write beats; resp_data is 0 outside read beats.
- Reset mid-burst: no further RAM write; the next cycle is IDLE with outputs 0. Partially written beats remain in the RAM.
- A req_valid arriving in DONE is not accepted until IDLE.

Decomposition:
- Shared package:
  - state enum (IDLE, PREFETCH, ACTIVE, DONE)
  - addr_t, len_t, strobe_t, word_t typedefs
  - BYTES_PER_WORD constant
- One sub-module: burst_addr_gen. It holds the start address, len and wrap, produces cur_addr and next_addr, and handles INCR/WRAP wrap-around.

Test Plan:
- Single write, addr=5, len=0, strobe=all-ones, data=0xDEADBEEF_00000001 -> one cycle with ram_en=1, ram_addr=5, resp_ready=1 and resp_last=1. A following read of addr 5 returns the same data.
- INCR write burst, addr=62, len=3, data 1,2,3,4 -> ram_addr sequence 62, 63, 0, 1. resp_last only on the 4th beat.
- WRAP read burst, len=3, addr=6, READ_LATENCY=1, RAM preloaded so word i holds i -> resp_data sequence 6, 7, 4, 5. First resp_ready arrives three cycles after req_valid.
- Partial strobe write 0x0F of 0xAAAAAAAA_BBBBBBBB over 0xFFFFFFFF_FFFFFFFF -> readback 0xFFFFFFFF_BBBBBBBB.
- Reset asserted on beat 2 of an 8-beat write -> ram_en=0 in the reset cycle and state returns to IDLE. Only beats 0–1 are written; a new request afterwards is served normally.
- Back-to-back transactions with req_valid re-asserted in DONE -> request ignored until IDLE. The second transaction starts exactly one cycle after DONE.

Source files
------------

// File: rtl/lutram_burst_responder_pkg.sv
// Shared types and constants for the LUT-RAM burst responder.
// Holds the FSM state encoding, default-sized word/address/strobe types and
// the byte-lanes-per-word constant used by the responder and its users.
package lutram_burst_responder_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 6;
  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned BYTE_WIDTH_DEF = 8;
  localparam int unsigned LEN_WIDTH_DEF  = 4;

  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH_DEF / BYTE_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    ACTIVE,
    DONE
  } state_t;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [LEN_WIDTH_DEF-1:0]  len_t;
  typedef logic [BYTES_PER_WORD-1:0] strobe_t;
  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/lutram_burst_responder_if.sv
// Requester-side bus of the LUT-RAM burst responder.
//   master : the cache/uncached requester (drives req_*, sees resp_*)
//   slave  : the responder (sees req_*, drives resp_*)
// req_valid is held until the cycle after the last beat; req_is_write,
// req_addr, req_len and req_wrap stay stable while it is high.
// req_strobe/req_data carry the write beat currently being offered.
interface lutram_burst_responder_if
  import lutram_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
);

  logic                           req_valid;
  logic                           req_is_write;
  logic [ADDR_WIDTH-1:0]          req_addr;
  logic [LEN_WIDTH-1:0]           req_len;
  logic                           req_wrap;
  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_strobe;
  logic [DATA_WIDTH-1:0]          req_data;
  logic                           resp_ready;
  logic                           resp_last;
  logic [DATA_WIDTH-1:0]          resp_data;

  modport master (
    output req_valid, req_is_write, req_addr, req_len, req_wrap,
           req_strobe, req_data,
    input  resp_ready, resp_last, resp_data
  );

  modport slave (
    input  req_valid, req_is_write, req_addr, req_len, req_wrap,
           req_strobe, req_data,
    output resp_ready, resp_last, resp_data
  );

endinterface

// File: rtl/lutram_burst_responder_burst_addr_gen.sv
// Burst address generator for the LUT-RAM burst responder.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture start_addr/start_len/start_wrap
//   step        : advance cur_addr to the next beat address
//   start_addr  : first word address of the burst
//   start_len   : beats minus one
//   start_wrap  : 1 = WRAP burst, 0 = INCR
//   cur_addr    : current issue address
//   len         : latched beats-minus-one
// INCR steps +1 modulo 2**ADDR_WIDTH. WRAP steps only the low log2(len+1)
// bits when len+1 is a power of two >= 2; any other WRAP length acts as INCR.
module burst_addr_gen
  import lutram_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  input  logic                  start_wrap,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic [LEN_WIDTH-1:0]  len
);

  logic [ADDR_WIDTH-1:0]           cur_q;
  logic [LEN_WIDTH-1:0]            len_q;
  logic                            wrap_q;
  logic [LEN_WIDTH:0]              span;
  logic                            wrap_ok;
  logic [ADDR_WIDTH+LEN_WIDTH-1:0] len_ext;
  logic [ADDR_WIDTH-1:0]           mask;
  logic [ADDR_WIDTH-1:0]           next_addr;

  // span = len+1; it is a power of two exactly when span & len == 0.
  assign span    = {1'b0, len_q} + (LEN_WIDTH+1)'(1);
  assign wrap_ok = wrap_q && (len_q != '0) && ((span & {1'b0, len_q}) == '0);
  assign len_ext = {{ADDR_WIDTH{1'b0}}, len_q};

  // For a legal wrap, len itself is the mask of the incrementing low bits.
  always_comb begin
    mask = '1;
    if (wrap_ok) begin
      mask = len_ext[ADDR_WIDTH-1:0];
    end
  end

  assign next_addr = (cur_q & ~mask) | ((cur_q + ADDR_WIDTH'(1)) & mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q  <= '0;
      len_q  <= '0;
      wrap_q <= 1'b0;
    end else if (load) begin
      cur_q  <= start_addr;
      len_q  <= start_len;
      wrap_q <= start_wrap;
    end else if (step) begin
      cur_q  <= next_addr;
    end
  end

  assign cur_addr = cur_q;
  assign len      = len_q;

endmodule

// File: rtl/lutram_burst_responder.sv
// Bus-side responder turning single/burst word reads and writes into
// one-beat-per-cycle accesses on port 1 of a dual-port distributed RAM.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : requester bus (slave side), see lutram_burst_responder_if
//   ram_en      : port-1 write enable (write beats only)
//   ram_addr    : port-1 address
//   ram_strobe  : port-1 byte write strobe
//   ram_wdata   : port-1 write data
//   ram_rdata   : port-1 read data (READ_LATENCY cycles after ram_addr)
// READ_LATENCY must be 0 or 1. Outputs are decoded from the registered
// state and forced to zero while reset is high.
module lutram_burst_responder
  import lutram_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH   = BYTE_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH    = LEN_WIDTH_DEF,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  lutram_burst_responder_if.slave          bus,
  output logic                             ram_en,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH/BYTE_WIDTH-1:0] ram_strobe,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  is_write_q;
  logic                  load;
  logic                  step;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  ready_c;
  logic                  last_c;
  logic [DATA_WIDTH-1:0] rdata_c;

  burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .start_addr (bus.req_addr),
    .start_len  (bus.req_len),
    .start_wrap (bus.req_wrap),
    .cur_addr   (cur_addr),
    .len        (len)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        is_write_q <= bus.req_is_write;
      end
    end
  end

  // The address generator's cur_addr is always the issue address: with
  // latency 1 the PREFETCH cycle issues beat 0, so during ACTIVE cur_addr is
  // already one beat ahead of the data returning on ram_rdata.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    step       = 1'b0;
    ram_en     = 1'b0;
    ram_addr   = '0;
    ram_strobe = '0;
    ram_wdata  = '0;
    ready_c    = 1'b0;
    last_c     = 1'b0;
    rdata_c    = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = (!bus.req_is_write && READ_LATENCY == 1) ? PREFETCH : ACTIVE;
        end
      end
      PREFETCH: begin
        ram_addr = cur_addr;
        step     = 1'b1;
        state_d  = ACTIVE;
      end
      ACTIVE: begin
        ready_c  = 1'b1;
        ram_addr = cur_addr;
        step     = 1'b1;
        last_c   = (cnt_q == len);
        cnt_d    = cnt_q + LEN_WIDTH'(1);
        if (is_write_q) begin
          ram_en     = 1'b1;
          ram_strobe = bus.req_strobe;
          ram_wdata  = bus.req_data;
        end else begin
          rdata_c = ram_rdata;
        end
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      ram_en     = 1'b0;
      ram_addr   = '0;
      ram_strobe = '0;
      ram_wdata  = '0;
      ready_c    = 1'b0;
      last_c     = 1'b0;
      rdata_c    = '0;
    end
  end

  assign bus.resp_ready = ready_c;
  assign bus.resp_last  = last_c;
  assign bus.resp_data  = rdata_c;

endmodule

// File: tb/tb_lutram_burst_responder.sv
// Scoreboard bench for lutram_burst_responder with a latency-1 RAM model.
// The driver computes every expected beat from a word-level reference
// memory and the burst address rules, pushes it into a queue, and a
// negedge monitor pops and compares whenever the responder presents a beat.
module tb_lutram_burst_responder;
  import lutram_burst_responder_pkg::*;

  localparam int unsigned AW = ADDR_WIDTH_DEF;
  localparam int unsigned DW = DATA_WIDTH_DEF;
  localparam int unsigned BW = BYTE_WIDTH_DEF;
  localparam int unsigned LW = LEN_WIDTH_DEF;
  localparam int unsigned RL = 1;
  localparam int unsigned DEPTH = 2**AW;

  typedef struct {
    logic    is_write;
    addr_t   addr;
    word_t   data;
    strobe_t strobe;
    logic    last;
  } beat_t;

  logic    clk = 1'b0;
  logic    reset;
  logic    preload;
  logic    ram_en;
  addr_t   ram_addr;
  strobe_t ram_strobe;
  word_t   ram_wdata;
  word_t   ram_rdata;
  word_t   rdata_q;

  word_t   mem     [DEPTH];
  word_t   ref_mem [DEPTH];
  beat_t   exp_q   [$];
  word_t   wdata_v [16];
  strobe_t wstrb_v [16];
  logic    prev_kept;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lutram_burst_responder_if #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BYTE_WIDTH (BW),
    .LEN_WIDTH  (LW)
  ) bus ();

  lutram_burst_responder #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .BYTE_WIDTH   (BW),
    .LEN_WIDTH    (LW),
    .READ_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_strobe (ram_strobe),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Distributed RAM port 1: byte-strobed write, registered or async read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= word_t'(i);
    end else if (ram_en) begin
      for (int b = 0; b < BYTES_PER_WORD; b++)
        if (ram_strobe[b]) mem[ram_addr][b*BW +: BW] <= ram_wdata[b*BW +: BW];
    end
    rdata_q <= mem[ram_addr];
  end
  assign ram_rdata = (RL == 1) ? rdata_q : mem[ram_addr];

  // Word address of beat i, straight from the INCR/WRAP rules.
  function automatic int unsigned beat_addr(int unsigned start, int unsigned len,
                                            logic wrap, int unsigned i);
    int unsigned n = len + 1;
    if (wrap && n >= 2 && (n & (n - 1)) == 0)
      return (start / n) * n + ((start % n) + i) % n;
    return (start + i) % DEPTH;
  endfunction

  // Monitor: every negedge either checks a presented beat against the
  // scoreboard or checks that nothing is being driven.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        checks++;
        if (ram_en !== 1'b0 || bus.resp_ready !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs: ram_en=%b resp_ready=%b, required 0 0",
                   ram_en, bus.resp_ready);
        end
      end else if (bus.resp_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: resp_ready=1 with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e.is_write) begin
            if (ram_en !== 1'b1 || ram_addr !== e.addr || ram_wdata !== e.data ||
                ram_strobe !== e.strobe || bus.resp_last !== e.last || bus.resp_data !== '0) begin
              errors++;
              $display("FAIL write_beat: en=%b addr=%0d wdata=%h strb=%h last=%b rdata=%h, required 1 %0d %h %h %b 0",
                       ram_en, ram_addr, ram_wdata, ram_strobe, bus.resp_last, bus.resp_data,
                       e.addr, e.data, e.strobe, e.last);
            end
          end else begin
            if (ram_en !== 1'b0 || bus.resp_data !== e.data || bus.resp_last !== e.last ||
                ram_wdata !== '0 || ram_strobe !== '0) begin
              errors++;
              $display("FAIL read_beat: en=%b rdata=%h last=%b wdata=%h strb=%h, required 0 %h %b 0 0 (addr %0d)",
                       ram_en, bus.resp_data, bus.resp_last, ram_wdata, ram_strobe,
                       e.data, e.last, e.addr);
            end
          end
        end
      end else begin
        checks++;
        if (bus.resp_ready !== 1'b0 || ram_en !== 1'b0 || bus.resp_last !== 1'b0 ||
            bus.resp_data !== '0 || ram_wdata !== '0 || ram_strobe !== '0) begin
          errors++;
          $display("FAIL idle_outputs: ready=%b en=%b last=%b rdata=%h wdata=%h strb=%h, required all 0",
                   bus.resp_ready, ram_en, bus.resp_last, bus.resp_data, ram_wdata, ram_strobe);
        end
      end
    end
  end

  // One transaction: push expected beats, then drive the requester side.
  // abort_beat >= 0 asserts reset once that many beats have been accepted.
  // keep_valid leaves req_valid high into DONE for a back-to-back request.
  task automatic do_txn(input logic wr, input int unsigned addr, input int unsigned len,
                        input logic wrap, input int abort_beat, input logic keep_valid);
    int unsigned nb = len + 1;
    int unsigned lim = (abort_beat >= 0) ? int'(abort_beat) : nb;
    int unsigned ba;
    int unsigned beat = 0;
    int unsigned waited = 0;
    int unsigned exp_lat;
    logic first = 1'b1;
    beat_t e;

    for (int unsigned i = 0; i < lim; i++) begin
      ba = beat_addr(addr, len, wrap, i);
      e.is_write = wr;
      e.addr     = addr_t'(ba);
      e.last     = (i == len);
      if (wr) begin
        e.data   = wdata_v[i];
        e.strobe = wstrb_v[i];
        for (int b = 0; b < BYTES_PER_WORD; b++)
          if (wstrb_v[i][b]) ref_mem[ba][b*BW +: BW] = wdata_v[i][b*BW +: BW];
      end else begin
        e.data   = ref_mem[ba];
        e.strobe = '0;
      end
      exp_q.push_back(e);
    end

    // First beat is seen 2 sampling cycles after req_valid rises, 3 for a
    // latency-1 read; a request raised during DONE waits one extra cycle.
    exp_lat = (!wr && RL == 1) ? 3 : 2;
    if (prev_kept) exp_lat++;

    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_is_write = wr;
    bus.req_addr     = addr_t'(addr);
    bus.req_len      = len_t'(len);
    bus.req_wrap     = wrap;
    bus.req_data     = wr ? wdata_v[0] : '0;
    bus.req_strobe   = wr ? wstrb_v[0] : '0;

    while (1) begin
      @(negedge clk);
      waited++;
      if (bus.resp_ready === 1'b1) begin
        if (first) begin
          checks++;
          if (waited != exp_lat) begin
            errors++;
            $display("FAIL first_beat_latency: got %0d cycles, required %0d", waited, exp_lat);
          end
          first = 1'b0;
        end
        beat++;
        if (abort_beat >= 0 && beat == int'(abort_beat)) begin
          @(posedge clk); #1;
          reset         = 1'b1;
          bus.req_valid = 1'b0;
          @(posedge clk); #1;
          reset     = 1'b0;
          prev_kept = 1'b0;
          return;
        end
        if (bus.resp_last === 1'b1 || beat >= nb) break;
        @(posedge clk); #1;
        bus.req_data   = wr ? wdata_v[beat] : '0;
        bus.req_strobe = wr ? wstrb_v[beat] : '0;
      end else if (!first) begin
        checks++;
        errors++;
        $display("FAIL throughput_gap: resp_ready=0 after beat %0d of %0d", beat, nb);
        break;
      end else if (waited > 20) begin
        checks++;
        errors++;
        $display("FAIL first_beat_timeout: no resp_ready within %0d cycles, required %0d", waited, exp_lat);
        break;
      end
    end

    if (keep_valid) begin
      prev_kept = 1'b1;
    end else begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      prev_kept     = 1'b0;
    end
  endtask

  task automatic fill_beats(input word_t d, input strobe_t s);
    for (int i = 0; i < 16; i++) begin
      wdata_v[i] = d + word_t'(i);
      wstrb_v[i] = s;
    end
  endtask

  initial begin
    logic        wr, w;
    int unsigned a, l;

    reset            = 1'b1;
    preload          = 1'b1;
    prev_kept        = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_write = 1'b0;
    bus.req_addr     = '0;
    bus.req_len      = '0;
    bus.req_wrap     = 1'b0;
    bus.req_strobe   = '0;
    bus.req_data     = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = word_t'(i);
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    preload = 1'b0;

    // WRAP read of a 4-word window starting mid-window: 6, 7, 4, 5.
    do_txn(1'b0, 6, 3, 1'b1, -1, 1'b0);

    // Single full-strobe write, then read it back.
    fill_beats(64'hDEADBEEF_00000001, '1);
    do_txn(1'b1, 5, 0, 1'b0, -1, 1'b0);
    do_txn(1'b0, 5, 0, 1'b0, -1, 1'b0);

    // INCR write crossing the top of the address space: 62, 63, 0, 1.
    fill_beats(64'd1, '1);
    do_txn(1'b1, 62, 3, 1'b0, -1, 1'b0);
    do_txn(1'b0, 62, 3, 1'b0, -1, 1'b0);

    // Partial strobe over all-ones.
    fill_beats(64'hFFFFFFFF_FFFFFFFF, '1);
    do_txn(1'b1, 20, 0, 1'b0, -1, 1'b0);
    fill_beats(64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    do_txn(1'b1, 20, 0, 1'b0, -1, 1'b0);
    do_txn(1'b0, 20, 0, 1'b0, -1, 1'b0);

    // Reset on beat 2 of an 8-beat write; only beats 0-1 land.
    fill_beats(64'h1234_5678_0000_0000, '1);
    do_txn(1'b1, 40, 7, 1'b0, 2, 1'b0);
    do_txn(1'b0, 40, 7, 1'b0, -1, 1'b0);

    // Back-to-back requests raised during DONE.
    fill_beats(64'h0B0B_0000_0000_0000, '1);
    do_txn(1'b1, 10, 1, 1'b0, -1, 1'b1);
    fill_beats(64'h0C0C_0000_0000_0000, '1);
    do_txn(1'b1, 12, 2, 1'b0, -1, 1'b1);
    do_txn(1'b0, 10, 4, 1'b0, -1, 1'b0);

    // WRAP with a non power-of-two length behaves as INCR.
    do_txn(1'b0, 30, 2, 1'b1, -1, 1'b0);

    // Randomized mix, including zero-strobe beats and DONE-cycle requests.
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, DEPTH - 1);
      l  = $urandom_range(0, 15);
      w  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        wdata_v[i] = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       wstrb_v[i] = '0;
          1:       wstrb_v[i] = '1;
          default: wstrb_v[i] = strobe_t'($urandom_range(0, 255));
        endcase
      end
      do_txn(wr, a, l, w, -1, ($urandom_range(0, 3) == 0));
    end

    // Final full read sweep of the whole memory.
    for (int i = 0; i < DEPTH; i += 16) do_txn(1'b0, i, 15, 1'b0, -1, 1'b0);

    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d beats never presented, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit reached");
  end

endmodule
